// File: rtl/risc_v_32_wb_arb.sv
// Writeback arbiter: buffers one result per execution source and drains the held
// results round-robin onto the register-file write ports, formatting loads on the way out.
module risc_v_32_wb_arb #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int NUM_WP  = 2,
  parameter int REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  input  logic [NUM_SRC-1:0]        src_is_load,
  input  logic [NUM_SRC*3-1:0]      src_funct3,
  input  logic [NUM_SRC*2-1:0]      src_boff,
  output logic [NUM_WP-1:0]         wp_en,
  output logic [NUM_WP*REG_AW-1:0]  wp_addr,
  output logic [NUM_WP*XLEN-1:0]    wp_data,
  output logic                      wb_busy
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] hold_v;
  logic [REG_AW-1:0]  hold_rd     [NUM_SRC];
  logic [XLEN-1:0]    hold_data   [NUM_SRC];
  logic [NUM_SRC-1:0] hold_is_load;
  logic [2:0]         hold_funct3 [NUM_SRC];
  logic [1:0]         hold_boff   [NUM_SRC];

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      rr_ptr_nxt;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_WP-1:0]  port_en;
  logic [REG_AW-1:0]  port_rd   [NUM_WP];
  logic [PW-1:0]      port_src  [NUM_WP];
  logic [XLEN-1:0]    port_data [NUM_WP];

  int   grant_cnt;
  int   scan_idx;
  logic rd_clash;

  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] w,
                                               input logic [2:0]      f3,
                                               input logic [1:0]      boff);
    logic [7:0]  b;
    logic [15:0] h;
    case (boff)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = boff[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  // Scan from the pointer, wrapping; an entry whose rd is already being written this cycle waits.
  always_comb begin
    grant      = '0;
    port_en    = '0;
    rr_ptr_nxt = rr_ptr;
    grant_cnt  = 0;
    scan_idx   = 0;
    rd_clash   = 1'b0;
    for (int p = 0; p < NUM_WP; p++) begin
      port_rd[p]  = '0;
      port_src[p] = '0;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_SRC) scan_idx = scan_idx - NUM_SRC;
      rd_clash = 1'b0;
      for (int p = 0; p < NUM_WP; p++) begin
        if (port_en[p] && (port_rd[p] == hold_rd[scan_idx])) rd_clash = 1'b1;
      end
      if (hold_v[scan_idx] && !rd_clash && (grant_cnt < NUM_WP)) begin
        grant[scan_idx]     = 1'b1;
        port_en[grant_cnt]  = 1'b1;
        port_rd[grant_cnt]  = hold_rd[scan_idx];
        port_src[grant_cnt] = PW'(scan_idx);
        rr_ptr_nxt          = (scan_idx == NUM_SRC - 1) ? '0 : PW'(scan_idx + 1);
        grant_cnt           = grant_cnt + 1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_WP; p++) begin
      port_data[p] = '0;
      if (port_en[p]) begin
        if (hold_is_load[port_src[p]])
          port_data[p] = fmt_load(hold_data[port_src[p]], hold_funct3[port_src[p]],
                                  hold_boff[port_src[p]]);
        else
          port_data[p] = hold_data[port_src[p]];
      end
    end
  end

  assign src_ready = ~hold_v | grant;
  assign wb_busy   = |hold_v;

  // A granted slot may be refilled on the same edge; rd==0 results are swallowed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v  <= '0;
      rr_ptr  <= '0;
      wp_en   <= '0;
      wp_addr <= '0;
      wp_data <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i])
          hold_v[i] <= (src_rd[i*REG_AW +: REG_AW] != '0);
        else if (grant[i])
          hold_v[i] <= 1'b0;
      end
      for (int p = 0; p < NUM_WP; p++) begin
        wp_en[p]                      <= port_en[p];
        wp_addr[p*REG_AW +: REG_AW]   <= port_rd[p];
        wp_data[p*XLEN +: XLEN]       <= port_data[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        hold_rd[i]      <= src_rd[i*REG_AW +: REG_AW];
        hold_data[i]    <= src_data[i*XLEN +: XLEN];
        hold_is_load[i] <= src_is_load[i];
        hold_funct3[i]  <= src_funct3[i*3 +: 3];
        hold_boff[i]    <= src_boff[i*2 +: 2];
      end
    end
  end

endmodule

// File: tb/tb_risc_v_32_wb_arb.sv
// Bench for risc_v_32_wb_arb: directed scenarios plus randomized traffic checked
// against a per-source pending-result model.
module tb_risc_v_32_wb_arb;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 4;
  localparam int NUM_WP  = 2;
  localparam int REG_AW  = 5;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*REG_AW-1:0] src_rd;
  logic [NUM_SRC*XLEN-1:0]   src_data;
  logic [NUM_SRC-1:0]        src_is_load;
  logic [NUM_SRC*3-1:0]      src_funct3;
  logic [NUM_SRC*2-1:0]      src_boff;
  logic [NUM_WP-1:0]         wp_en;
  logic [NUM_WP*REG_AW-1:0]  wp_addr;
  logic [NUM_WP*XLEN-1:0]    wp_data;
  logic                      wb_busy;

  risc_v_32_wb_arb #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_WP(NUM_WP), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd),
    .src_data(src_data), .src_is_load(src_is_load), .src_funct3(src_funct3),
    .src_boff(src_boff), .wp_en(wp_en), .wp_addr(wp_addr), .wp_data(wp_data),
    .wb_busy(wb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one pending (already formatted) result per source plus a scan start.
  bit                 m_v    [NUM_SRC];
  logic [REG_AW-1:0]  m_rd   [NUM_SRC];
  logic [31:0]        m_val  [NUM_SRC];
  int                 m_ptr;
  logic [NUM_WP-1:0]  m_en;
  logic [REG_AW-1:0]  m_addr [NUM_WP];
  logic [31:0]        m_data [NUM_WP];
  int                 m_order[$];
  bit                 m_grant[NUM_SRC];

  logic [NUM_SRC-1:0]       exp_ready;
  logic                     exp_busy;
  logic [NUM_WP-1:0]        exp_en;
  logic [NUM_WP*REG_AW-1:0] exp_addr;
  logic [NUM_WP*XLEN-1:0]   exp_data;

  int          wr_rd[$];
  logic [31:0] wr_data[$];
  int          acc_cnt;

  function automatic logic [31:0] ref_fmt(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] bo, input logic ld);
    logic [31:0] b;
    logic [31:0] h;
    if (!ld) return w;
    b = (w >> (8 * bo)) & 32'h0000_00FF;
    h = (w >> (16 * (bo / 2))) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic void model_arb();
    bit taken;
    int s;
    m_order.delete();
    for (int i = 0; i < NUM_SRC; i++) m_grant[i] = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = (m_ptr + k) % NUM_SRC;
      taken = 1'b0;
      foreach (m_order[j]) if (m_rd[m_order[j]] == m_rd[s]) taken = 1'b1;
      if (m_v[s] && !taken && m_order.size() < NUM_WP) begin
        m_order.push_back(s);
        m_grant[s] = 1'b1;
      end
    end
  endfunction

  function automatic void model_outputs();
    model_arb();
    exp_busy = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      exp_ready[s] = !m_v[s] || m_grant[s];
      exp_busy     = exp_busy | m_v[s];
    end
    for (int p = 0; p < NUM_WP; p++) begin
      exp_en[p]                    = m_en[p];
      exp_addr[p*REG_AW +: REG_AW] = m_addr[p];
      exp_data[p*XLEN +: XLEN]     = m_data[p];
    end
  endfunction

  function automatic void model_step();
    bit rdy;
    model_arb();
    if (rst) begin
      for (int s = 0; s < NUM_SRC; s++) m_v[s] = 1'b0;
      for (int p = 0; p < NUM_WP; p++) begin
        m_en[p] = 1'b0; m_addr[p] = '0; m_data[p] = '0;
      end
      m_ptr = 0;
      return;
    end
    for (int p = 0; p < NUM_WP; p++) begin
      if (p < m_order.size()) begin
        m_en[p] = 1'b1; m_addr[p] = m_rd[m_order[p]]; m_data[p] = m_val[m_order[p]];
      end else begin
        m_en[p] = 1'b0; m_addr[p] = '0; m_data[p] = '0;
      end
    end
    if (m_order.size() > 0) m_ptr = (m_order[m_order.size()-1] + 1) % NUM_SRC;
    for (int s = 0; s < NUM_SRC; s++) begin
      rdy = !m_v[s] || m_grant[s];
      if (m_grant[s]) m_v[s] = 1'b0;
      if (src_valid[s] && rdy && src_rd[s*REG_AW +: REG_AW] != '0) begin
        m_v[s]   = 1'b1;
        m_rd[s]  = src_rd[s*REG_AW +: REG_AW];
        m_val[s] = ref_fmt(src_data[s*XLEN +: XLEN], src_funct3[s*3 +: 3],
                           src_boff[s*2 +: 2], src_is_load[s]);
      end
    end
  endfunction

  // Advance one clock; inputs are stable here, outputs are sampled 1ns after the edge.
  task automatic tick();
    for (int s = 0; s < NUM_SRC; s++)
      if (!rst && src_valid[s] && src_ready[s] && src_rd[s*REG_AW +: REG_AW] != '0)
        acc_cnt++;
    model_step();
    @(posedge clk);
    #1;
    for (int p = 0; p < NUM_WP; p++) begin
      if (wp_en[p]) begin
        wr_rd.push_back(int'(wp_addr[p*REG_AW +: REG_AW]));
        wr_data.push_back(wp_data[p*XLEN +: XLEN]);
      end
    end
  endtask

  task automatic clear_inputs();
    src_valid = '0; src_rd = '0; src_data = '0;
    src_is_load = '0; src_funct3 = '0; src_boff = '0;
  endtask

  task automatic drive_src(input int s, input logic [REG_AW-1:0] rd, input logic [31:0] d,
                           input logic ld, input logic [2:0] f3, input logic [1:0] bo);
    src_valid[s]                = 1'b1;
    src_rd[s*REG_AW +: REG_AW]  = rd;
    src_data[s*XLEN +: XLEN]    = d;
    src_is_load[s]              = ld;
    src_funct3[s*3 +: 3]        = f3;
    src_boff[s*2 +: 2]          = bo;
  endtask

  task automatic reset_pulse();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = 4'hF; src_rd = 20'hABCDE; src_data = {4{$urandom()}};
    src_is_load = '0; src_funct3 = '0; src_boff = '0;
    tick(); tick();
    clear_inputs();
    rst = 1'b0;
    checks++; if (wp_en !== '0) begin errors++; $display("[TB] FAIL reset_wp_en got=%b exp=0", wp_en); end
    checks++; if (wp_addr !== '0) begin errors++; $display("[TB] FAIL reset_wp_addr got=%h exp=0", wp_addr); end
    checks++; if (wp_data !== '0) begin errors++; $display("[TB] FAIL reset_wp_data got=%h exp=0", wp_data); end
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", wb_busy); end
    checks++; if (src_ready !== 4'hF) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1111", src_ready); end
  endtask

  task automatic test_single();
    drive_src(0, 5'd5, 32'hDEAD_BEEF, 1'b0, 3'b0, 2'b0);
    tick();
    clear_inputs();
    checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_ready got=%b exp=1", src_ready[0]); end
    checks++; if (wb_busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got=%b exp=1", wb_busy); end
    tick();
    checks++; if (wp_en !== 2'b01) begin errors++; $display("[TB] FAIL single_en got=%b exp=01", wp_en); end
    checks++; if (wp_addr[REG_AW-1:0] !== 5'd5) begin errors++; $display("[TB] FAIL single_addr got=%0d exp=5", wp_addr[REG_AW-1:0]); end
    checks++; if (wp_data[XLEN-1:0] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_data got=%h exp=deadbeef", wp_data[XLEN-1:0]); end
    drive_src(0, 5'd9, 32'h1234_5678, 1'b0, 3'b0, 2'b0);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (wp_en !== '0) begin errors++; $display("[TB] FAIL midreset_en got=%b exp=00", wp_en); end
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got=%b exp=0", wb_busy); end
    tick();
    checks++; if (wp_en !== '0) begin errors++; $display("[TB] FAIL midreset_discard got=%b exp=00", wp_en); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  bo_tab  [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] exp_tab [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F1,
                                 32'h0000_7F01, 32'h80F1_7F01};
    for (int i = 0; i < 5; i++) begin
      drive_src(1, REG_AW'(10 + i), 32'h80F1_7F01, 1'b1, f3_tab[i], bo_tab[i]);
      tick();
      clear_inputs();
      tick();
      checks++;
      if (wp_en !== 2'b01 || wp_data[XLEN-1:0] !== exp_tab[i] || wp_addr[REG_AW-1:0] !== REG_AW'(10 + i)) begin
        errors++;
        $display("[TB] FAIL load_%0d got en=%b rd=%0d data=%h exp en=01 rd=%0d data=%h",
                 i, wp_en, wp_addr[REG_AW-1:0], wp_data[XLEN-1:0], 10 + i, exp_tab[i]);
      end
    end
  endtask

  task automatic test_rd_zero();
    drive_src(1, 5'd0, 32'hCAFE_F00D, 1'b0, 3'b0, 2'b0);
    #1;
    checks++; if (src_ready[1] !== 1'b1) begin errors++; $display("[TB] FAIL rd0_ready got=%b exp=1", src_ready[1]); end
    tick();
    clear_inputs();
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("[TB] FAIL rd0_busy got=%b exp=0", wb_busy); end
    tick();
    checks++; if (wp_en !== '0) begin errors++; $display("[TB] FAIL rd0_wp_en got=%b exp=00", wp_en); end
  endtask

  task automatic test_collision();
    reset_pulse();
    drive_src(0, 5'd7, 32'hAAAA_0000, 1'b0, 3'b0, 2'b0);
    drive_src(2, 5'd7, 32'h0000_BBBB, 1'b0, 3'b0, 2'b0);
    tick();
    clear_inputs();
    checks++; if (src_ready !== 4'b1011) begin errors++; $display("[TB] FAIL clash_ready got=%b exp=1011", src_ready); end
    tick();
    checks++;
    if (wp_en !== 2'b01 || wp_addr[REG_AW-1:0] !== 5'd7 || wp_data[XLEN-1:0] !== 32'hAAAA_0000) begin
      errors++;
      $display("[TB] FAIL clash_first got en=%b rd=%0d data=%h exp en=01 rd=7 data=aaaa0000",
               wp_en, wp_addr[REG_AW-1:0], wp_data[XLEN-1:0]);
    end
    tick();
    checks++;
    if (wp_en !== 2'b01 || wp_addr[REG_AW-1:0] !== 5'd7 || wp_data[XLEN-1:0] !== 32'h0000_BBBB) begin
      errors++;
      $display("[TB] FAIL clash_second got en=%b rd=%0d data=%h exp en=01 rd=7 data=0000bbbb",
               wp_en, wp_addr[REG_AW-1:0], wp_data[XLEN-1:0]);
    end
    drive_src(0, 5'd11, 32'h1111_1111, 1'b0, 3'b0, 2'b0);
    drive_src(3, 5'd12, 32'h3333_3333, 1'b0, 3'b0, 2'b0);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (wp_en !== 2'b11 || wp_addr !== {5'd11, 5'd12}) begin
      errors++;
      $display("[TB] FAIL clash_pointer got en=%b addr=%h exp en=11 port0=12 port1=11", wp_en, wp_addr);
    end
  endtask

  task automatic test_backpressure();
    int  start;
    int  cnt_a;
    int  cnt_b;
    bit  taken;
    bit  rdy3;
    reset_pulse();
    for (int s = 0; s < 3; s++) drive_src(s, REG_AW'(s + 1), $urandom(), 1'b0, 3'b0, 2'b0);
    drive_src(3, 5'd20, 32'hA0A0_A0A0, 1'b0, 3'b0, 2'b0);
    tick();
    start = wr_rd.size();
    drive_src(3, 5'd21, 32'hB1B1_B1B1, 1'b0, 3'b0, 2'b0);
    taken = 1'b0;
    for (int c = 0; c < 10 && !taken; c++) begin
      model_outputs();
      checks++;
      if (src_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL bp_ready cyc=%0d got=%b exp=%b", c, src_ready, exp_ready);
      end
      rdy3 = src_ready[3];
      for (int s = 0; s < 3; s++)
        if (src_ready[s]) src_data[s*XLEN +: XLEN] = $urandom();
      tick();
      if (rdy3) begin
        taken = 1'b1;
        src_valid[3] = 1'b0;
      end
    end
    if (!taken) begin
      checks++; errors++;
      $display("[TB] FAIL bp_timeout src3 never ready got=0 exp=1");
    end
    clear_inputs();
    for (int c = 0; c < 4; c++) tick();
    cnt_a = 0; cnt_b = 0;
    for (int i = start; i < wr_rd.size(); i++) begin
      if (wr_rd[i] == 20 && wr_data[i] == 32'hA0A0_A0A0) cnt_a++;
      if (wr_rd[i] == 21 && wr_data[i] == 32'hB1B1_B1B1) cnt_b++;
    end
    checks++; if (cnt_a != 1) begin errors++; $display("[TB] FAIL bp_first_once got=%0d exp=1", cnt_a); end
    checks++; if (cnt_b != 1) begin errors++; $display("[TB] FAIL bp_second_once got=%0d exp=1", cnt_b); end
  endtask

  task automatic test_back_to_back();
    logic [NUM_SRC-1:0] pat;
    reset_pulse();
    wr_rd.delete(); wr_data.delete();
    acc_cnt = 0;
    for (int s = 0; s < NUM_SRC; s++) drive_src(s, REG_AW'(8 + s), $urandom(), 1'b0, 3'b0, 2'b0);
    for (int c = 0; c < 20; c++) begin
      model_outputs();
      pat = (c == 0) ? 4'b1111 : ((c % 2 == 1) ? 4'b0011 : 4'b1100);
      checks++;
      if (src_ready !== pat || src_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL b2b_ready cyc=%0d got=%b exp=%b", c, src_ready, pat);
      end
      checks++;
      if (wp_en !== exp_en || wp_addr !== exp_addr || wp_data !== exp_data) begin
        errors++;
        $display("[TB] FAIL b2b_write cyc=%0d got en=%b addr=%h data=%h exp en=%b addr=%h data=%h",
                 c, wp_en, wp_addr, wp_data, exp_en, exp_addr, exp_data);
      end
      for (int s = 0; s < NUM_SRC; s++)
        if (src_ready[s]) src_data[s*XLEN +: XLEN] = $urandom();
      tick();
    end
    clear_inputs();
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (wr_rd.size() != acc_cnt) begin
      errors++;
      $display("[TB] FAIL b2b_count got=%0d writes exp=%0d accepted", wr_rd.size(), acc_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      model_outputs();
      checks++;
      if (src_ready !== exp_ready || wb_busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL rand_ready cyc=%0d got ready=%b busy=%b exp ready=%b busy=%b",
                 c, src_ready, wb_busy, exp_ready, exp_busy);
      end
      checks++;
      if (wp_en !== exp_en || wp_addr !== exp_addr || wp_data !== exp_data) begin
        errors++;
        $display("[TB] FAIL rand_write cyc=%0d got en=%b addr=%h data=%h exp en=%b addr=%h data=%h",
                 c, wp_en, wp_addr, wp_data, exp_en, exp_addr, exp_data);
      end
      rst = ($urandom_range(0, 39) == 0);
      for (int s = 0; s < NUM_SRC; s++) begin
        src_valid[s]               = ($urandom_range(0, 2) != 0);
        src_rd[s*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        src_data[s*XLEN +: XLEN]   = $urandom();
        src_is_load[s]             = $urandom_range(0, 1) == 1;
        src_funct3[s*3 +: 3]       = 3'($urandom_range(0, 7));
        src_boff[s*2 +: 2]         = 2'($urandom_range(0, 3));
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    for (int s = 0; s < NUM_SRC; s++) begin
      m_v[s] = 1'b0; m_rd[s] = '0; m_val[s] = '0;
    end
    for (int p = 0; p < NUM_WP; p++) begin
      m_en[p] = 1'b0; m_addr[p] = '0; m_data[p] = '0;
    end
    m_ptr   = 0;
    acc_cnt = 0;
    #1;
    test_reset();
    test_single();
    test_loads();
    test_rd_zero();
    test_collision();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
